// File: rtl/calc_op_sequencer.sv
// Clocked valid/ready front-end for the combinational calculate_2 core (ap_ctrl_hs),
// with a result FIFO and a watchdog. Optional perf counters: CALC_SEQ_PERF_CNT_EN.
module calc_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              calc_ap_start,
  input  logic              calc_ap_done,
  input  logic              calc_ap_idle,
  input  logic              calc_ap_ready,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  input  logic [DATA_W-1:0] calc_ap_return,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
`ifdef CALC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [15:0]       perf_timeouts
`endif
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [15:0]       wd_q, wd_d, wd_inc;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            push_entry, head;
  logic              push, pop, timeout_hit;
  logic              core_idle_unused;

  // Core idle is advisory only; the FSM relies on start/ready/done.
  assign core_idle_unused = calc_ap_idle;

  assign in_ready    = (state_q == S_IDLE) && (cnt_q < DEPTH_C) && !ap_rst;
  assign out_valid   = (cnt_q != '0);
  assign pop         = out_valid && out_ready;
  assign head        = mem_q[rd_ptr_q];
  assign out_data    = out_valid ? head.data : '0;
  assign out_err     = out_valid ? head.err  : 1'b0;
  assign busy        = (state_q != S_IDLE) || out_valid;
  assign calc_a      = a_q;
  assign calc_b      = b_q;

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    wd_d          = wd_q;
    push          = 1'b0;
    push_entry    = '0;
    calc_ap_start = 1'b0;
    wd_inc        = wd_q + 16'd1;
    timeout_hit   = (wd_inc == TIMEOUT_C);
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          wd_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        calc_ap_start = 1'b1;
        wd_d          = wd_inc;
        if (calc_ap_done) begin
          push       = 1'b1;
          push_entry = '{err: 1'b0, data: calc_ap_return};
          state_d    = S_IDLE;
        end else if (timeout_hit) begin
          push       = 1'b1;
          push_entry = '{err: 1'b1, data: '0};
          state_d    = S_IDLE;
        end else if (calc_ap_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (calc_ap_done) begin
          push       = 1'b1;
          push_entry = '{err: 1'b0, data: calc_ap_return};
          state_d    = S_IDLE;
        end else if (timeout_hit) begin
          push       = 1'b1;
          push_entry = '{err: 1'b1, data: '0};
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot is reserved at accept, so push never finds the FIFO full.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wd_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wd_q     <= wd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef CALC_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_to_q, perf_to_d;

  always_comb begin
    perf_ops_d = perf_ops_q;
    perf_to_d  = perf_to_q;
    if (push && (perf_ops_q != '1)) perf_ops_d = perf_ops_q + 32'd1;
    if (push && push_entry.err && (perf_to_q != '1)) perf_to_d = perf_to_q + 16'd1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      perf_ops_q <= '0;
      perf_to_q  <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_to_q  <= perf_to_d;
    end
  end

  assign perf_ops      = perf_ops_q;
  assign perf_timeouts = perf_to_q;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: behavioural core with programmable latency/hang,
// table of single ops, stream/full/reset sequences, and a randomized scoreboard run.
module tb_calc_op_sequencer;
  localparam int DW = 32;
  localparam int TO = 10;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [DW-1:0] in_a, in_b, calc_a, calc_b, calc_ap_return, out_data;
  logic          calc_ap_start, calc_ap_done, calc_ap_idle, calc_ap_ready;
`ifdef CALC_SEQ_PERF_CNT_EN
  logic [31:0]   perf_ops;
  logic [15:0]   perf_timeouts;
`endif

  calc_op_sequencer #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .calc_ap_start(calc_ap_start), .calc_ap_done(calc_ap_done),
    .calc_ap_idle(calc_ap_idle), .calc_ap_ready(calc_ap_ready),
    .calc_a(calc_a), .calc_b(calc_b), .calc_ap_return(calc_ap_return),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
`ifdef CALC_SEQ_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_timeouts(perf_timeouts)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Behavioural core: done arrives core_lat cycles after start is first seen.
  logic core_ph;
  int   core_cnt, core_lat, eff;
  bit   hang;
  logic core_act;
  assign core_act       = core_ph || calc_ap_start;
  assign eff            = core_ph ? core_cnt : 0;
  assign calc_ap_done   = !hang && core_act && (eff == core_lat);
  assign calc_ap_ready  = calc_ap_start;
  assign calc_ap_idle   = !core_act;
  assign calc_ap_return = calc_a + calc_b;

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      core_ph <= 1'b0; core_cnt <= 0;
    end else if (calc_ap_done || hang) begin
      core_ph <= 1'b0; core_cnt <= 0;
    end else if (core_act) begin
      core_ph <= 1'b1; core_cnt <= eff + 1;
    end
  end

  typedef struct {
    logic [DW-1:0] a, b;
    int            lat;
    bit            hang;
    logic [DW-1:0] exp_d;
    bit            exp_e;
    int            exp_cyc;
  } vec_t;

  typedef struct { logic err; logic [DW-1:0] d; } res_t;

  vec_t tbl[7];
  res_t exp_q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0, acc_cnt = 0, last_acc = 0;
  int   exp_ops = 0, exp_to = 0;
  bit   mon_en = 0, chk_iv = 0, rnd_lat = 0, acc_now = 0, hold_v = 0;
  logic [DW:0] hold_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    res_t e;
    acc_now = 0;
    if (hold_v) chk("hold_stable", {31'd0, out_valid, out_err, out_data}, {31'd0, 1'b1, hold_d});
    if (in_valid && in_ready) begin
      if (chk_iv && acc_cnt > 0) chk("accept_interval", 64'(cyc - last_acc), 64'd2);
      e.err = hang;
      e.d   = hang ? '0 : in_a + in_b;
      exp_q.push_back(e);
      exp_ops++;
      if (hang) exp_to++;
      acc_cnt++; last_acc = cyc; acc_now = 1;
      if (rnd_lat) core_lat = $urandom_range(0, 8);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {31'd0, out_err, out_data}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", {31'd0, out_err, out_data}, {31'd0, e.err, e.d});
      end
    end
    hold_v = out_valid && !out_ready;
    hold_d = {out_err, out_data};
  endtask

  task automatic step();
    @(negedge ap_clk);
    cyc++;
    if (mon_en) monitor();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid); k++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic new_data();
    in_a = $urandom; in_b = $urandom;
  endtask

  initial begin
    int  n;
    bit  ok, seen;
    tbl[0] = '{32'd3,        32'd5,        0, 1'b0, 32'd8,        1'b0, 2};
    tbl[1] = '{32'hffffffff, 32'd1,        0, 1'b0, 32'd0,        1'b0, 2};
    tbl[2] = '{32'ha5a5a5a5, 32'h5a5a5a5a, 3, 1'b0, 32'hffffffff, 1'b0, 5};
    tbl[3] = '{32'd1,        32'd2,        0, 1'b1, 32'd0,        1'b1, TO + 1};
    tbl[4] = '{32'd100,      32'd23,       0, 1'b0, 32'd123,      1'b0, 2};
    tbl[5] = '{32'd7,        32'd9,        TO - 1, 1'b0, 32'd16,  1'b0, TO + 1};
    tbl[6] = '{32'd0,        32'd0,        8, 1'b0, 32'd0,        1'b0, 10};

    ap_rst = 1'b1; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0;
    core_lat = 0; hang = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_start",     {63'd0, calc_ap_start}, 64'd0);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    chk("rst_calc_ab",   {calc_a, calc_b}, 64'd0);
    chk("rst_out",       {31'd0, out_err, out_data}, 64'd0);
    ap_rst = 1'b0;
    step();

    // Back-to-back stream, one accept every 2 cycles.
    mon_en = 1; chk_iv = 1; out_ready = 1; acc_cnt = 0; new_data(); in_valid = 1;
    for (int k = 0; k < 100 && acc_cnt < 8; k++) begin
      step();
      if (acc_now) new_data();
    end
    in_valid = 0; chk_iv = 0;
    chk("stream_accepts", 64'(acc_cnt), 64'd8);
    drain();

    // FIFO fills with consumer stalled; pop does not raise in_ready combinationally.
    out_ready = 0; acc_cnt = 0; new_data(); in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acc_now) new_data();
    end
    chk("full_accepts", 64'(acc_cnt), 64'd4);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1;
    #1 chk("pop_not_comb", {63'd0, in_ready}, 64'd0);
    step();
    chk("pop_then_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 50 && acc_cnt < 6; k++) begin
      step();
      if (acc_now) new_data();
    end
    in_valid = 0;
    chk("full_total_accepts", 64'(acc_cnt), 64'd6);
    drain();

    // Reset during ISSUE with two results queued.
    out_ready = 0; acc_cnt = 0; core_lat = 0; new_data(); in_valid = 1;
    for (int k = 0; k < 40 && acc_cnt < 2; k++) begin
      step();
      if (acc_now) new_data();
    end
    in_valid = 0;
    repeat (3) step();
    core_lat = 5; in_valid = 1;
    for (int k = 0; k < 40 && acc_cnt < 3; k++) step();
    in_valid = 0;
    #2 ap_rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready",  {63'd0, in_ready}, 64'd0);
    chk("mid_rst_start",     {63'd0, calc_ap_start}, 64'd0);
    chk("mid_rst_busy",      {63'd0, busy}, 64'd0);
    chk("mid_rst_calc_ab",   {calc_a, calc_b}, 64'd0);
    chk("mid_rst_out",       {31'd0, out_err, out_data}, 64'd0);
    exp_q.delete(); exp_ops = 0; exp_to = 0; hold_v = 0;
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    mon_en = 0; out_ready = 1; seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_result", {63'd0, seen}, 64'd0);
    out_ready = 0;

    // Single-op table: latency, data, error tag, idle after pop.
    foreach (tbl[i]) begin
      core_lat = tbl[i].lat; hang = tbl[i].hang;
      in_a = tbl[i].a; in_b = tbl[i].b; in_valid = 1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge ap_clk); ok = in_ready; @(posedge ap_clk); #1;
      end
      in_valid = 0;
      chk("tbl_accept", {63'd0, ok}, 64'd1);
      exp_ops++;
      if (tbl[i].hang) exp_to++;
      n = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge ap_clk); n++; seen = out_valid;
        if (!seen) begin @(posedge ap_clk); #1; end
      end
      chk("tbl_latency", 64'(n), 64'(tbl[i].exp_cyc));
      chk("tbl_result", {31'd0, out_err, out_data}, {31'd0, tbl[i].exp_e, tbl[i].exp_d});
      chk("tbl_start_low", {63'd0, calc_ap_start}, 64'd0);
      @(posedge ap_clk); #1 out_ready = 1;
      @(posedge ap_clk); #1 out_ready = 0;
      chk("tbl_idle_after_pop", {62'd0, out_valid, busy}, 64'd0);
    end
    hang = 0;

    // Randomized traffic against the in-order scoreboard.
    mon_en = 1; rnd_lat = 1; core_lat = $urandom_range(0, 8); new_data();
    for (int k = 0; k < 600; k++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc_now) new_data();
    end
    in_valid = 0; out_ready = 1;
    drain();
`ifdef CALC_SEQ_PERF_CNT_EN
    chk("perf_ops", 64'(perf_ops), 64'(exp_ops));
    chk("perf_timeouts", 64'(perf_timeouts), 64'(exp_to));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
